// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//
// Purpose:
//   Hardware instruction source for the cpu. It walks a synchronous-read
//   instruction memory from address 0 and issues one 16-bit word per cycle on
//   the cpu instruction input. It stops at HALT_WORD, or after MEM_DEPTH words
//   if no halt word is found (overflow). When no program word is issued, it
//   drives NOP_WORD.
//
// Optional feature (macro RESULT_CAPTURE_EN):
//   The cpu result for every issued instruction is captured one cycle after
//   issue into a RESULT_DEPTH-entry FIFO that a host drains. While the FIFO is
//   nearly full, issue stalls (STALL state). The held word is issued first when
//   space frees up. Without the macro the result port is tied to 0 and
//   cpu_output_in is ignored.
//
// Ports:
//   clock_in, reset_in        : clock, synchronous active-high reset
//   start_in                  : begin a run at address 0 (IDLE/DONE only)
//   mem_addr_out, mem_data_in : instruction memory (data one cycle after addr)
//   current_instruction_out   : word to cpu (NOP_WORD when not valid)
//   instruction_valid_out     : current word is a program word
//   cpu_output_in             : cpu result, sampled the cycle after issue
//   busy_out, done_out        : run in progress / run finished (held)
//   overflow_out              : run ended at MEM_DEPTH without a halt word
//   instruction_count_out     : program words issued this run
//   result_valid_out/_data_out/result_ready_in : result FIFO head handshake
// -----------------------------------------------------------------------------
module instruction_sequencer #(
  parameter int                     INSTR_WIDTH  = 16,
  parameter int                     ADDR_WIDTH   = 14,
  parameter int                     MEM_DEPTH    = 16384,
  parameter int                     DATA_WIDTH   = 8,
  parameter int                     RESULT_DEPTH = 8,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD    = 16'hFFFF,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD     = 16'h9000
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   start_in,
  output logic [ADDR_WIDTH-1:0]  mem_addr_out,
  input  logic [INSTR_WIDTH-1:0] mem_data_in,
  output logic [INSTR_WIDTH-1:0] current_instruction_out,
  output logic                   instruction_valid_out,
  input  logic [DATA_WIDTH-1:0]  cpu_output_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   overflow_out,
  output logic [ADDR_WIDTH:0]    instruction_count_out,
  output logic                   result_valid_out,
  output logic [DATA_WIDTH-1:0]  result_data_out,
  input  logic                   result_ready_in
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_LAST  = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_STALL,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   fifo_clear;
  logic                   issue_en;
  logic [INSTR_WIDTH-1:0] issue_word;

`ifdef RESULT_CAPTURE_EN
  localparam int                PTR_W       = $clog2(RESULT_DEPTH);
  localparam logic [PTR_W:0]    FIFO_FULL   = (PTR_W + 1)'(RESULT_DEPTH);
  localparam logic [PTR_W:0]    STALL_LEVEL = (PTR_W + 1)'(RESULT_DEPTH - 1);

  logic [INSTR_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0]  fifo_mem [RESULT_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]         fifo_cnt_q, fifo_cnt_d;
  logic                   push_en, pop_en, stall_cond;

  // valid_q marks the instruction the cpu is executing this cycle, so its
  // result is on cpu_output_in right now and is captured on this edge.
  assign pop_en     = result_ready_in && (fifo_cnt_q != '0);
  assign push_en    = valid_q && ((fifo_cnt_q != FIFO_FULL) || pop_en);
  assign fifo_cnt_d = fifo_cnt_q + (PTR_W + 1)'(push_en) - (PTR_W + 1)'(pop_en);
  // Occupancy after this edge; one slot stays free for the word issued now.
  assign stall_cond = (fifo_cnt_d >= STALL_LEVEL);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = NOP_WORD;
    valid_d    = 1'b0;
    count_d    = count_q;
    overflow_d = overflow_q;
    fifo_clear = 1'b0;
    issue_en   = 1'b0;
    issue_word = mem_data_in;
`ifdef RESULT_CAPTURE_EN
    hold_d     = hold_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          state_d    = S_PRIME;
          addr_d     = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          fifo_clear = 1'b1;
        end
      end
      S_PRIME: begin
        // Address 0 is in flight; move the fetch pointer one word ahead.
        state_d = S_RUN;
        addr_d  = (ADDR_LAST != '0) ? ADDR_WIDTH'(1) : '0;
      end
      S_RUN: begin
        if (mem_data_in == HALT_WORD) begin
          state_d = S_DONE;
`ifdef RESULT_CAPTURE_EN
        end else if (stall_cond) begin
          hold_d  = mem_data_in;
          state_d = S_STALL;
`endif
        end else begin
          issue_en = 1'b1;
        end
      end
      S_STALL: begin
`ifdef RESULT_CAPTURE_EN
        // The address was frozen, so the memory is already returning the
        // word after the held one by the time the held word is issued.
        if (!stall_cond) begin
          issue_en   = 1'b1;
          issue_word = hold_q;
          state_d    = S_RUN;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (issue_en) begin
      instr_d = issue_word;
      valid_d = 1'b1;
      count_d = count_q + (ADDR_WIDTH + 1)'(1);
      // count_q equals the address of the word being issued.
      if (count_q == CNT_LAST) begin
        state_d    = S_DONE;
        overflow_d = 1'b1;
      end else if (addr_q != ADDR_LAST) begin
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef RESULT_CAPTURE_EN
  always_ff @(posedge clock_in) begin
    if (reset_in || fifo_clear) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      hold_q     <= NOP_WORD;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_d;
      hold_q     <= hold_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (push_en) fifo_mem[wr_ptr_q] <= cpu_output_in;
  end

  assign result_valid_out = (fifo_cnt_q != '0);
  assign result_data_out  = fifo_mem[rd_ptr_q];
`else
  logic unused_inputs;
  assign unused_inputs    = ^{cpu_output_in, result_ready_in, fifo_clear};
  assign result_valid_out = 1'b0;
  assign result_data_out  = '0;
`endif

  assign mem_addr_out            = addr_q;
  assign current_instruction_out = instr_q;
  assign instruction_valid_out   = valid_q;
  assign instruction_count_out   = count_q;
  assign overflow_out            = overflow_q;
  assign busy_out                = (state_q == S_PRIME) || (state_q == S_RUN) ||
                                   (state_q == S_STALL);
  assign done_out                = (state_q == S_DONE);

endmodule

// File: tb/tb_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instruction_sequencer
//
// Drives instruction_sequencer with a behavioural ROM and a behavioural cpu
// (result = simple function of the presented instruction). Expected words and
// results come from walking the ROM contents up to the halt word or
// MEM_DEPTH. A monitor pops and compares them whenever the DUT presents a
// valid instruction or a result handshake.
// -----------------------------------------------------------------------------
module tb_instruction_sequencer;
  localparam int IW = 16;
  localparam int AW = 14;
  localparam int MD = 16;
  localparam int DW = 8;
  localparam int RD = 4;
  localparam logic [IW-1:0] HALT = 16'hFFFF;
  localparam logic [IW-1:0] NOP  = 16'h9000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic [AW-1:0] addr;
  logic [IW-1:0] mem_data;
  logic [IW-1:0] instr;
  logic          valid;
  logic [DW-1:0] cpu_out;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [AW:0]   cnt;
  logic          res_valid;
  logic [DW-1:0] res_data;

  always #5 clk = ~clk;

  instruction_sequencer #(
    .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .MEM_DEPTH(MD), .DATA_WIDTH(DW),
    .RESULT_DEPTH(RD), .HALT_WORD(HALT), .NOP_WORD(NOP)
  ) dut (
    .clock_in(clk),
    .reset_in(rst),
    .start_in(start),
    .mem_addr_out(addr),
    .mem_data_in(mem_data),
    .current_instruction_out(instr),
    .instruction_valid_out(valid),
    .cpu_output_in(cpu_out),
    .busy_out(busy),
    .done_out(done),
    .overflow_out(ovf),
    .instruction_count_out(cnt),
    .result_valid_out(res_valid),
    .result_data_out(res_data),
    .result_ready_in(ready)
  );

  // Behavioural ROM with one cycle of read latency.
  logic [IW-1:0] rom [MD];
  always @(posedge clk) mem_data <= (addr < AW'(MD)) ? rom[addr[3:0]] : 16'h0BAD;

  // Behavioural cpu result.
  function automatic logic [DW-1:0] cpu_model(input logic [IW-1:0] w);
    return w[15:8] ^ w[7:0] ^ 8'h5A;
  endfunction
  assign cpu_out = cpu_model(instr);

  int n_checks = 0;
  int n_fail   = 0;
  int issued   = 0;
  bit mon_en   = 1'b0;
  bit rand_ready = 1'b0;

  logic [IW-1:0] exp_instr_q[$];
  logic [DW-1:0] exp_res_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid === 1'b1) begin
        issued++;
        if (exp_instr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL instr_unexpected: got %h, expected no valid word", instr);
        end else begin
          check("instr_word", instr, exp_instr_q.pop_front());
        end
      end else begin
        check("nop_fill", instr, NOP);
      end
      check("addr_bound", addr <= AW'(MD - 1), 1);
`ifdef RESULT_CAPTURE_EN
      if (res_valid === 1'b1 && ready === 1'b1) begin
        if (exp_res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL result_unexpected: got %h, expected no result", res_data);
        end else begin
          check("result_data", res_data, exp_res_q.pop_front());
        end
      end
`else
      check("result_idle", {res_valid, res_data}, 0);
`endif
      $display("cycle: addr=%0d instr=%h valid=%b busy=%b done=%b ovf=%b cnt=%0d res_v=%b",
               addr, instr, valid, busy, done, ovf, cnt, res_valid);
    end
  end

  // Random host back-pressure, changed away from both clock edges.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int len, input bit with_halt);
    logic [IW-1:0] w;
    for (int i = 0; i < MD; i++) begin
      w = IW'($urandom);
      if (w == HALT) w = 16'h1234;
      rom[i] = w;
    end
    if (with_halt && len < MD) rom[len] = HALT;
  endtask

  // Reference: the program is every word before the first halt, at most MD.
  task automatic expect_prog(output int n, output bit ovf_exp);
    n = 0;
    while (n < MD && rom[n] != HALT) begin
      exp_instr_q.push_back(rom[n]);
`ifdef RESULT_CAPTURE_EN
      exp_res_q.push_back(cpu_model(rom[n]));
`endif
      n++;
    end
    ovf_exp = (n == MD);
  endtask

  task automatic wait_done(output int first, output int done_at);
    first   = -1;
    done_at = -1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (valid === 1'b1 && first < 0) first = k;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    if (done_at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: done_out %b after 400 cycles, expected 1", done);
    end
  endtask

  task automatic drain_results();
`ifdef RESULT_CAPTURE_EN
    for (int k = 0; k < 200 && exp_res_q.size() != 0; k++) tick();
    check("results_drained", exp_res_q.size(), 0);
`endif
  endtask

  task automatic run_and_check(input string tag, input bit exact);
    int n;
    bit oe;
    int first;
    int done_at;
    expect_prog(n, oe);
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    issued = 0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_addr_after_start"}, addr, 0);
    wait_done(first, done_at);
    if (exact) begin
      check({tag, "_first_valid_cycle"}, first, (n > 0) ? 2 : -1);
      check({tag, "_done_cycle"}, done_at, oe ? MD + 1 : n + 2);
    end
    check({tag, "_count"}, cnt, n);
    check({tag, "_overflow"}, ovf, oe);
    check({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    #1;
    check({tag, "_instr_queue_empty"}, exp_instr_q.size(), 0);
    check({tag, "_issued"}, issued, n);
    drain_results();
  endtask

  initial begin
    int n;
    bit oe;
    int first;
    int done_at;

    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < MD; i++) rom[i] = HALT;
    tick(); tick(); tick();
    check("rst_addr", addr, 0);
    check("rst_instr", instr, NOP);
    check("rst_flags", {valid, busy, done, ovf, res_valid}, 0);
    check("rst_count", cnt, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Two-word program.
    load_prog(3, 1'b1);
    rom[0] = 16'h0123;
    rom[1] = 16'h4567;
    rom[2] = HALT;
    run_and_check("two_words", 1'b1);

    // Halt at address 0.
    rom[0] = HALT;
    run_and_check("halt_first", 1'b1);

    // No halt word: runs to MEM_DEPTH and flags overflow.
    load_prog(MD, 1'b0);
    run_and_check("overflow", 1'b1);

    // start held high across a 5-word run, then into DONE.
    load_prog(5, 1'b1);
    expect_prog(n, oe);
    @(negedge clk);
    start = 1'b1;
    tick();
    issued = 0;
    wait_done(first, done_at);
    check("held_done_cycle", done_at, 7);
    check("held_count", cnt, 5);
    expect_prog(n, oe);
    tick();
    check("held_restart_busy", busy, 1);
    check("held_restart_done", done, 0);
    check("held_restart_addr", addr, 0);
    check("held_restart_count", cnt, 0);
    start = 1'b0;
    issued = 0;
    wait_done(first, done_at);
    check("held_second_count", cnt, 5);
    @(negedge clk);
    #1;
    check("held_second_issued", issued, 5);
    drain_results();

    // Reset during the third RUN cycle.
    load_prog(10, 1'b1);
    expect_prog(n, oe);
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    exp_instr_q.delete();
    exp_res_q.delete();
    check("midrst_addr", addr, 0);
    check("midrst_instr", instr, NOP);
    check("midrst_flags", {valid, busy, done, ovf, res_valid}, 0);
    check("midrst_count", cnt, 0);
    rst = 1'b0;
    run_and_check("after_reset", 1'b1);

    // Randomised programs (random back-pressure when results are captured).
`ifdef RESULT_CAPTURE_EN
    rand_ready = 1'b1;
`endif
    for (int it = 0; it < 6; it++) begin
      int len;
      len = int'($urandom_range(0, MD));
      load_prog(len, len < MD);
`ifdef RESULT_CAPTURE_EN
      run_and_check($sformatf("rand%0d", it), 1'b0);
`else
      run_and_check($sformatf("rand%0d", it), 1'b1);
`endif
    end
    rand_ready = 1'b0;
    @(negedge clk);
    ready = 1'b1;

`ifdef RESULT_CAPTURE_EN
    // Host stalled: issue stops with the FIFO one short of full.
    ready = 1'b0;
    load_prog(10, 1'b1);
    expect_prog(n, oe);
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    issued = 0;
    for (int k = 0; k < 14; k++) tick();
    check("stall_issued", issued, 3);
    check("stall_busy", busy, 1);
    check("stall_done", done, 0);
    check("stall_addr_frozen", addr, 4);
    check("stall_head", {res_valid, res_data}, {1'b1, cpu_model(rom[0])});
    @(negedge clk);
    ready = 1'b1;
    wait_done(first, done_at);
    check("stall_count", cnt, 10);
    @(negedge clk);
    #1;
    check("stall_issued_total", issued, 10);
    drain_results();
    check("stall_fifo_empty", res_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at 500000, expected to finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

- Hardware instruction source for `cpu`:
  - fetches 16-bit words from a synchronous-read instruction memory;
  - presents them one per cycle on the CPU's instruction input;
  - stops at the halt word `16'hFFFF`.
- Sits between the instruction ROM and `cpu`, and replaces the bench-driven instruction feed for on-chip runs.
- Optionally captures `cpu_output` for every issued instruction into a result FIFO that a host drains.

## Interface
- `INSTR_WIDTH`, 16: instruction word width.
- `ADDR_WIDTH`, 14: memory address width.
- `MEM_DEPTH`, 16384: words fetched before overflow; must be ≤ 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8: `cpu_output` width (signed, bits 7:0).
- `RESULT_DEPTH`, 8: result FIFO entries; power of two, ≥ 4.
- `HALT_WORD`, 16'hFFFF: end-of-program marker.
- `NOP_WORD`, 16'h9000: word driven when no instruction is issued (NOP opcode 4'b1001).
- `clock_in`, in, 1: single clock; all state on rising edge.
- `reset_in`, in, 1: synchronous, active-high reset.
- `start_in`, in, 1: begin run at address 0; sampled only in IDLE/DONE.
- `mem_addr_out`, out, ADDR_WIDTH: instruction memory address.
- `mem_data_in`, in, INSTR_WIDTH: memory data, valid one cycle after address.
- `current_instruction_out`, out, INSTR_WIDTH: instruction to `cpu`.
- `instruction_valid_out`, out, 1: current instruction is a program word, not filler.
- `cpu_output_in`, in, DATA_WIDTH: `cpu.cpu_output`.
- `busy_out`, out, 1: run in progress.
- `done_out`, out, 1: run ended; held until next start or reset.
- `overflow_out`, out, 1: run ended at MEM_DEPTH without a halt word.
- `instruction_count_out`, out, ADDR_WIDTH+1: program words issued this run.
- `result_valid_out`, out, 1: FIFO head valid.
- `result_data_out`, out, DATA_WIDTH: FIFO head.
- `result_ready_in`, in, 1: host pops the head when high with valid.

## Operation
- States: IDLE, PRIME, RUN, STALL, DONE.
- IDLE → PRIME on `start_in`:
  - address, count, overflow and FIFO cleared;
  - `mem_addr_out`=0.
- PRIME → RUN after one cycle; `mem_addr_out`=1.
- RUN, each edge, samples `mem_data_in` (word at the previously issued address):
  - word == HALT_WORD → DONE; output NOP_WORD, valid=0; count not incremented.
  - Otherwise: register the word onto `current_instruction_out`, set valid=1, increment count, increment `mem_addr_out`.
  - After issuing the word at address MEM_DEPTH-1 with no halt seen → DONE with `overflow_out`=1. Address never wraps.
- STALL: exists only with capture enabled; see Configuration.
- DONE: `done_out`=1, `busy_out`=0. `start_in` restarts the run (same as from IDLE).
- `start_in` is ignored in PRIME, RUN and STALL.
- Whenever valid=0, `current_instruction_out`=NOP_WORD.
- Reset values: state IDLE; `mem_addr_out`=0; `current_instruction_out`=NOP_WORD; every other output 0; FIFO emptied.
- Reset asserted mid-run wins over every other event on that edge.

## Timing
- `start_in` sampled at edge E0 → first program word visible after E2 (latency 2).
- One instruction per cycle thereafter.
- `done_out` rises on the edge that samples the halt word; that is the cycle after the last program word is issued.
- `busy_out` is high from the edge after start until the edge that sets `done_out`.
- `cpu_output_in` for the instruction issued at edge N is sampled at edge N+1.

## Configuration
- Macro: `RESULT_CAPTURE_EN`.
- Defined:
  - Each valid instruction's result (sampled at N+1) is pushed into the FIFO.
  - In RUN, if FIFO occupancy ≥ RESULT_DEPTH−1 (one slot reserved for the in-flight capture), the sampled word moves to a hold register and the state goes to STALL. `mem_addr_out` freezes and NOP/valid=0 is issued.
  - STALL → RUN on the first edge with occupancy < RESULT_DEPTH−1; the held word is issued first.
  - Push and pop on the same edge are both performed, including when the FIFO is full.
  - Pops require `result_valid_out`; no data is dropped.
- Undefined: no FIFO or STALL state; `result_valid_out`=0 and `result_data_out`=0 constant; `cpu_output_in` unused.

## Test plan
- Memory {0x0123, 0x4567, 0xFFFF}, pulse start:
  - 0x0123 valid after E2, 0x4567 after E3;
  - `done_out`=1 after E4;
  - count=2, overflow=0.
- mem[0]=0xFFFF: done after E2; valid never asserted; count=0; output stays 0x9000.
- MEM_DEPTH=8, no halt word: 8 words issued; then done=1 and overflow=1; `mem_addr_out` never exceeds 7.
- Reset asserted on the third RUN cycle:
  - next edge gives IDLE, addr=0, NOP, all flags 0;
  - a new start restarts from address 0 with count reset.
- `start_in` held high through a 5-word run: no restart during RUN; when held into DONE, a second run begins from address 0.
- `RESULT_CAPTURE_EN`, RESULT_DEPTH=4, ready=0, 10-word program:
  - stall after 3 words are issued;
  - raise ready: all 10 results pop in issue order, none lost or duplicated; done after the last word.
